// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Package : motor_pkg
// Brief   : Duty word geometry and ramp-controller state encoding.
// Rev     : 1.0
// ============================================================================
package motor_pkg;

  localparam int DUTY_W = 13;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = 13'h1FFF;
  localparam logic [DUTY_W-1:0] DUTY_HALF = 13'h0FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_STOP = 2'd2
  } motor_state_e;

endpackage
`default_nettype wire

// File: rtl/motor_ramp_step.sv
`default_nettype none
// ============================================================================
// Module : motor_ramp_step
// Brief  : One channel, one ramp step toward target, saturated to 0..DUTY_MAX.
// Rev    : 1.0
// ============================================================================
module motor_ramp_step
  import motor_pkg::*;
#(
  parameter logic [DUTY_W-1:0] STEP = 13'h0040
) (
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] next_duty
);

  logic [DUTY_W:0] up_sum;
  logic [DUTY_W:0] dn_diff;
  logic [DUTY_W:0] gap;

  always_comb begin
    up_sum  = {1'b0, duty} + {1'b0, STEP};
    dn_diff = {1'b0, duty} - {1'b0, STEP};
    gap     = (target >= duty) ? ({1'b0, target} - {1'b0, duty})
                               : ({1'b0, duty} - {1'b0, target});
    next_duty = duty;
    if (gap <= {1'b0, STEP}) begin
      next_duty = target;
    end else if (target > duty) begin
      next_duty = up_sum[DUTY_W] ? DUTY_MAX : up_sum[DUTY_W-1:0];
    end else begin
      // borrow out of the 14-bit subtract means we went below zero
      next_duty = dn_diff[DUTY_W] ? '0 : dn_diff[DUTY_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : motor_ramp_ctrl
// Brief  : Dual-channel duty ramp controller with estop and optional command
//          watchdog (enabled by defining MOTOR_RAMP_WATCHDOG_EN).
// Rev    : 1.0
// ============================================================================
module motor_ramp_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned       RAMP_DIV   = 1000,
  parameter logic [DUTY_W-1:0] STEP       = 13'h0040,
  parameter logic [31:0]       WDT_CYCLES = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty_a,
  input  logic [DUTY_W-1:0] cmd_duty_b,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty_a,
  output logic [DUTY_W-1:0] duty_b,
  output logic              standby,
  output logic              busy,
  output logic              wdt_trip
);

  localparam logic [15:0] TICK_LAST = 16'(RAMP_DIV - 1);

  motor_state_e      state_q, state_d;
  logic [DUTY_W-1:0] duty_a_q, duty_a_d, duty_b_q, duty_b_d;
  logic [DUTY_W-1:0] tgt_a_q, tgt_a_d, tgt_b_q, tgt_b_d;
  logic [15:0]       tick_q, tick_d;
  logic              standby_q, standby_d, busy_q, busy_d, ready_q, ready_d;
  logic [DUTY_W-1:0] step_a, step_b;
  logic              accept;

  motor_ramp_step #(.STEP(STEP)) u_step_a (.duty(duty_a_q), .target(tgt_a_q), .next_duty(step_a));
  motor_ramp_step #(.STEP(STEP)) u_step_b (.duty(duty_b_q), .target(tgt_b_q), .next_duty(step_b));

`ifdef MOTOR_RAMP_WATCHDOG_EN
  logic [31:0] wdt_q, wdt_d;
  logic        wdt_trip_q, wdt_trip_d;
  logic        wdt_expire;
`else
  logic unused_cfg;
  assign unused_cfg = ^WDT_CYCLES;
`endif

  assign accept = cmd_valid && (state_q != ST_STOP);

  always_comb begin
    state_d  = state_q;
    duty_a_d = duty_a_q;
    duty_b_d = duty_b_q;
    tgt_a_d  = tgt_a_q;
    tgt_b_d  = tgt_b_q;
    tick_d   = tick_q;
`ifdef MOTOR_RAMP_WATCHDOG_EN
    wdt_trip_d = 1'b0;
    wdt_expire = 1'b0;
    wdt_d      = '0;
    if ((tgt_a_q != '0) || (tgt_b_q != '0)) begin
      if (wdt_q == WDT_CYCLES - 32'd1) wdt_expire = 1'b1;
      else                             wdt_d      = wdt_q + 32'd1;
    end
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_a_d = cmd_duty_a;
          tgt_b_d = cmd_duty_b;
          if ((cmd_duty_a != duty_a_q) || (cmd_duty_b != duty_b_q)) begin
            state_d = ST_RAMP;
            tick_d  = '0;
          end
        end
      end
      ST_RAMP: begin
        if (tick_q == TICK_LAST) begin
          duty_a_d = step_a;
          duty_b_d = step_b;
          tick_d   = '0;
        end else begin
          tick_d = tick_q + 16'd1;
        end
        // a retarget keeps the tick phase; leaving only when nothing new arrived
        if (accept) begin
          tgt_a_d = cmd_duty_a;
          tgt_b_d = cmd_duty_b;
        end else if ((duty_a_q == tgt_a_q) && (duty_b_q == tgt_b_q)) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MOTOR_RAMP_WATCHDOG_EN
    if (state_q == ST_STOP || accept) begin
      wdt_d = '0;
    end else if (wdt_expire) begin
      tgt_a_d    = '0;
      tgt_b_d    = '0;
      state_d    = ST_RAMP;
      wdt_trip_d = 1'b1;
      wdt_d      = '0;
    end
`endif

    if (estop) begin
      state_d  = ST_STOP;
      duty_a_d = '0;
      duty_b_d = '0;
      tgt_a_d  = '0;
      tgt_b_d  = '0;
      tick_d   = '0;
`ifdef MOTOR_RAMP_WATCHDOG_EN
      wdt_d      = '0;
      wdt_trip_d = 1'b0;
`endif
    end

    standby_d = (state_d != ST_STOP);
    ready_d   = (state_d != ST_STOP);
    busy_d    = (state_d == ST_RAMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      duty_a_q  <= '0;
      duty_b_q  <= '0;
      tgt_a_q   <= '0;
      tgt_b_q   <= '0;
      tick_q    <= '0;
      standby_q <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef MOTOR_RAMP_WATCHDOG_EN
      wdt_q      <= '0;
      wdt_trip_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      duty_a_q  <= duty_a_d;
      duty_b_q  <= duty_b_d;
      tgt_a_q   <= tgt_a_d;
      tgt_b_q   <= tgt_b_d;
      tick_q    <= tick_d;
      standby_q <= standby_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
`ifdef MOTOR_RAMP_WATCHDOG_EN
      wdt_q      <= wdt_d;
      wdt_trip_q <= wdt_trip_d;
`endif
    end
  end

  assign duty_a    = duty_a_q;
  assign duty_b    = duty_b_q;
  assign standby   = standby_q;
  assign busy      = busy_q;
  assign cmd_ready = ready_q;
`ifdef MOTOR_RAMP_WATCHDOG_EN
  assign wdt_trip = wdt_trip_q;
`else
  assign wdt_trip = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_motor_ramp_ctrl
// Brief  : Directed + random bench for motor_ramp_ctrl against a cycle model.
// Rev    : 1.0
// ============================================================================
module tb_motor_ramp_ctrl;

  localparam int RDIV = 4;
  localparam int STP  = 256;
  localparam int WDT  = 1000;

  logic        clk, rst_n, cmd_valid, cmd_ready, estop, standby, busy, wdt_trip;
  logic [12:0] cmd_duty_a, cmd_duty_b, duty_a, duty_b;

  int total = 0;
  int bad   = 0;

  // model of the controller: mode 0 idle, 1 ramping, 2 stopped
  int m_mode, m_da, m_db, m_ta, m_tb, m_tick, m_wdt;
  bit m_trip;

  motor_ramp_ctrl #(.RAMP_DIV(RDIV), .STEP(13'h100), .WDT_CYCLES(32'd1000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_duty_a(cmd_duty_a), .cmd_duty_b(cmd_duty_b), .estop(estop),
    .duty_a(duty_a), .duty_b(duty_b), .standby(standby), .busy(busy),
    .wdt_trip(wdt_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mstep(int d, int t);
    if (t >= d) return (t - d <= STP) ? t : ((d + STP > 8191) ? 8191 : d + STP);
    return (d - t <= STP) ? t : ((d - STP < 0) ? 0 : d - STP);
  endfunction

  task automatic m_reset();
    m_mode = 0; m_da = 0; m_db = 0; m_ta = 0; m_tb = 0;
    m_tick = 0; m_wdt = 0; m_trip = 0;
  endtask

  task automatic m_edge();
    int oa, ob, da0, db0, nw;
    bit expire;
    oa = m_ta; ob = m_tb; da0 = m_da; db0 = m_db;
    m_trip = 0;
    if (estop) begin
      m_mode = 2; m_da = 0; m_db = 0; m_ta = 0; m_tb = 0; m_tick = 0; m_wdt = 0;
      return;
    end
    if (m_mode == 2) begin
      m_mode = 0; m_wdt = 0;
      return;
    end
    expire = 0;
    nw = 0;
    if (oa != 0 || ob != 0) begin
      if (m_wdt == WDT - 1) expire = 1;
      else nw = m_wdt + 1;
    end
    if (m_mode == 1) begin
      if (m_tick == RDIV - 1) begin
        m_da = mstep(da0, oa); m_db = mstep(db0, ob); m_tick = 0;
      end else m_tick++;
      if (cmd_valid) begin
        m_ta = int'(cmd_duty_a); m_tb = int'(cmd_duty_b);
      end else if (da0 == oa && db0 == ob) begin
        m_mode = 0; m_tick = 0;
      end
    end else if (cmd_valid) begin
      m_ta = int'(cmd_duty_a); m_tb = int'(cmd_duty_b);
      if (m_ta != m_da || m_tb != m_db) begin m_mode = 1; m_tick = 0; end
    end
`ifdef MOTOR_RAMP_WATCHDOG_EN
    if (cmd_valid) m_wdt = 0;
    else if (expire) begin
      m_ta = 0; m_tb = 0; m_mode = 1; m_trip = 1; m_wdt = 0;
    end else m_wdt = nw;
`else
    if (expire || nw != 0) m_wdt = 0;
`endif
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("duty_a", 32'(duty_a), 32'(m_da));
    chk("duty_b", 32'(duty_b), 32'(m_db));
    chk("standby", 32'(standby), 32'(m_mode != 2));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_mode != 2));
    chk("busy", 32'(busy), 32'(m_mode == 1));
    chk("wdt_trip", 32'(wdt_trip), 32'(m_trip));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_edge();
    #1;
    check_all();
  endtask

  task automatic send(int a, int b);
    cmd_valid = 1'b1; cmd_duty_a = 13'(a); cmd_duty_b = 13'(b);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(int max);
    for (int i = 0; i < max && m_mode != 0; i++) cycle();
    chk("settle_busy", 32'(busy), 32'h0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_duty_a"}, 32'(duty_a), 32'h0);
    chk({tag, "_duty_b"}, 32'(duty_b), 32'h0);
    chk({tag, "_standby"}, 32'(standby), 32'h1);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_trip"}, 32'(wdt_trip), 32'h0);
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 0;
    if (r == 1) return 8191;
    return int'($urandom_range(0, 8191));
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; estop = 1'b0;
    cmd_duty_a = '0; cmd_duty_b = '0;
    m_reset();
    #12;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // long ramp: a to 0FFF in 16 steps, b to 1FFF in 32 steps
    send(13'h0FFF, 13'h1FFF);
    for (int i = 1; i <= 130; i++) begin
      cycle();
      if (i == 63)  chk("a_before_done", 32'(duty_a), 32'h0F00);
      if (i == 64)  chk("a_done_64", 32'(duty_a), 32'h0FFF);
      if (i == 128) chk("b_done_128", 32'(duty_b), 32'h1FFF);
      if (i == 128) chk("busy_at_128", 32'(busy), 32'h1);
      if (i == 129) chk("busy_drop_129", 32'(busy), 32'h0);
    end

    send(13'h0800, 13'h0800);
    run_until_idle(200);
    send(0, 0);
    for (int i = 1; i <= 4; i++) cycle();
    chk("down_first_step", 32'(duty_a), 32'h0700);
    run_until_idle(200);
    chk("down_a_zero", 32'(duty_a), 32'h0);
    chk("down_b_zero", 32'(duty_b), 32'h0);

    // equal-target accept must not start a ramp
    send(0, 0);
    chk("eq_accept_idle", 32'(busy), 32'h0);

    // estop mid-ramp at 0x0600, with a competing accept
    send(13'h1000, 13'h1000);
    for (int i = 0; i < 100 && m_da != 13'h0600; i++) cycle();
    chk("pre_estop_duty", 32'(duty_a), 32'h0600);
    estop = 1'b1; cmd_valid = 1'b1; cmd_duty_a = 13'h1FFF; cmd_duty_b = 13'h1FFF;
    cycle();
    cmd_valid = 1'b0;
    chk("estop_duty", 32'(duty_a), 32'h0);
    chk("estop_standby", 32'(standby), 32'h0);
    chk("estop_ready", 32'(cmd_ready), 32'h0);
    cycle(); cycle();
    estop = 1'b0;
    cycle();
    chk("release_standby", 32'(standby), 32'h1);
    chk("release_duty", 32'(duty_b), 32'h0);
    cycle();

    // retarget mid-ramp
    send(13'h0500, 13'h0300);
    repeat (6) cycle();
    send(13'h0100, 13'h1000);
    run_until_idle(300);

    for (int i = 0; i < 500; i++) begin
      cmd_valid  = ($urandom_range(0, 7) == 0);
      cmd_duty_a = 13'(pick());
      cmd_duty_b = 13'(pick());
      estop      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    cmd_valid = 1'b0; estop = 1'b0;
    cycle();
    run_until_idle(400);

`ifdef MOTOR_RAMP_WATCHDOG_EN
    estop = 1'b1; cycle(); estop = 1'b0; cycle();
    send(13'h0400, 13'h0400);
    for (int i = 1; i <= 1000; i++) begin
      cycle();
      if (i == 999)  chk("wdt_quiet", 32'(wdt_trip), 32'h0);
      if (i == 1000) chk("wdt_pulse", 32'(wdt_trip), 32'h1);
    end
    cycle();
    chk("wdt_one_cycle", 32'(wdt_trip), 32'h0);
    run_until_idle(40);
    chk("wdt_zero", 32'(duty_a), 32'h0);
`endif

    // asynchronous reset in the middle of a ramp
    send(13'h1FFF, 13'h1FFF);
    repeat (10) cycle();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    m_reset();
    @(posedge clk); #1;
    chk_reset_vals("held");
    rst_n = 1'b1;
    repeat (8) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
